bsg_wait_after_reset_seq: RTL and testbench

Multi-channel, runtime-programmable reset-release sequencer. After reset, or after a synchronous restart, it asserts a registered ready bit per channel in strict order 0..channels_p-1. Each release follows a programmable number of wait cycles and can be paused by a hold input. It sits between the chip-level reset tree and downstream blocks (PLL-gated logic, memories, links) that must leave reset staggered rather than simultaneously.

---
 rtl/bsg_wait_after_reset_seq.sv | 103 ++++++++++
 tb/tb_bsg_wait_after_reset_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_wait_after_reset_seq.sv
// Staggered reset-release sequencer: raises one ready bit per channel,
// in order, each after a programmable, holdable wait.
module bsg_wait_after_reset_seq #(
   parameter int channels_p = 4,
   parameter int lg_wait_cycles_p = 8,
   localparam int stage_width_lp = (channels_p > 1) ? $clog2(channels_p) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        restart_i,
   input  logic                        hold_i,
   input  logic [lg_wait_cycles_p-1:0] wait_cycles_i,
   output logic [channels_p-1:0]       ready_r_o,
   output logic [stage_width_lp-1:0]   stage_r_o,
   output logic                        done_r_o
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [stage_width_lp-1:0] last_stage_lp =
      stage_width_lp'(channels_p - 1);

   state_e                      state_r, state_n;
   logic [lg_wait_cycles_p-1:0] counter_r, counter_n;
   logic [lg_wait_cycles_p-1:0] wait_r, wait_n;
   logic [stage_width_lp-1:0]   stage_n;
   logic [channels_p-1:0]       ready_n;
   logic                        done_n;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r   <= LOAD;
         counter_r <= '0;
         wait_r    <= '0;
         stage_r_o <= '0;
         ready_r_o <= '0;
         done_r_o  <= 1'b0;
      end else begin
         state_r   <= state_n;
         counter_r <= counter_n;
         wait_r    <= wait_n;
         stage_r_o <= stage_n;
         ready_r_o <= ready_n;
         done_r_o  <= done_n;
      end
   end

   always_comb begin
      state_n   = state_r;
      counter_n = counter_r;
      wait_n    = wait_r;
      stage_n   = stage_r_o;
      ready_n   = ready_r_o;
      done_n    = done_r_o;
      // restart wins over everything, including a release on this edge
      if (restart_i) begin
         ready_n   = '0;
         done_n    = 1'b0;
         stage_n   = '0;
         counter_n = '0;
         state_n   = LOAD;
      end else begin
         case (state_r)
            LOAD: begin
               wait_n    = wait_cycles_i;
               counter_n = '0;
               state_n   = COUNT;
            end
            COUNT: begin
               if (!hold_i) begin
                  if (counter_r == wait_r) begin
                     for (int k = 0; k < channels_p; k++) begin
                        if (stage_width_lp'(k) == stage_r_o) begin
                           ready_n[k] = 1'b1;
                        end
                     end
                     if (stage_r_o == last_stage_lp) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                     end else begin
                        stage_n = stage_r_o + stage_width_lp'(1);
                        state_n = LOAD;
                     end
                  end else begin
                     counter_n = counter_r + lg_wait_cycles_p'(1);
                  end
               end
            end
            DONE: begin
               state_n = DONE;
            end
            default: begin
               state_n = LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bsg_wait_after_reset_seq.sv
// Self-checking bench for bsg_wait_after_reset_seq: directed release
// schedules plus randomized hold/restart/wait against an edge-level model.
module tb_bsg_wait_after_reset_seq;

   localparam int CH = 4;
   localparam int LG = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          restart = 1'b0;
   logic          hold = 1'b0;
   logic [LG-1:0] wait_cycles = '0;
   logic [CH-1:0] ready;
   logic [1:0]    stage;
   logic          done;

   int checks = 0;
   int failures = 0;

   bsg_wait_after_reset_seq #(
      .channels_p(CH),
      .lg_wait_cycles_p(LG)
   ) dut (
      .clk_i(clk),
      .reset_n_i(reset_n),
      .restart_i(restart),
      .hold_i(hold),
      .wait_cycles_i(wait_cycles),
      .ready_r_o(ready),
      .stage_r_o(stage),
      .done_r_o(done)
   );

   always #5 clk = ~clk;

   // Reference: a stage spends one edge sampling W, then needs W+1
   // un-held edges before its channel is released.
   logic [CH-1:0] m_ready;
   int            m_stage;
   bit            m_done;
   int            m_pos;
   int            m_w;

   task automatic model_clear();
      m_ready = '0;
      m_stage = 0;
      m_done  = 1'b0;
      m_pos   = 0;
      m_w     = 0;
   endtask

   task automatic model_edge();
      if (restart) begin
         model_clear();
      end else if (!m_done) begin
         if (m_pos == 0) begin
            m_w   = int'(wait_cycles);
            m_pos = 1;
         end else if (!hold) begin
            m_pos++;
            if (m_pos == m_w + 2) begin
               m_ready[m_stage] = 1'b1;
               if (m_stage == CH - 1) m_done = 1'b1;
               else m_stage++;
               m_pos = 0;
            end
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   // Reset spans one posedge; the edge after release is edge 1.
   task automatic start(input int w);
      restart = 1'b0;
      hold = 1'b0;
      wait_cycles = LG'(w);
      @(negedge clk);
      reset_n = 1'b0;
      model_clear();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      start(3);
      checks++;
      if ({ready, stage, done} !== 7'b0) begin
         failures++;
         $display("FAIL reset_state: got %b want %b",
                  {ready, stage, done}, 7'b0);
      end
      for (int e = 1; e <= 25; e++) begin
         tick();
         checks++;
         if ({ready, stage, done} !== {m_ready, 2'(m_stage), m_done}) begin
            failures++;
            $display("FAIL reset_seq e%0d: got %b want %b", e,
                     {ready, stage, done}, {m_ready, 2'(m_stage), m_done});
         end
         if (e == 4 || e == 5 || e == 10 || e == 15 || e == 20) begin
            checks++;
            if (ready !== ((e == 4) ? 4'b0000 : (e == 5) ? 4'b0001 :
                           (e == 10) ? 4'b0011 : (e == 15) ? 4'b0111 :
                           4'b1111) || done !== (e == 20)) begin
               failures++;
               $display("FAIL reset_spot e%0d: got %b/%b", e, ready, done);
            end
         end
      end
   endtask

   task automatic test_w0();
      start(0);
      for (int e = 1; e <= 58; e++) begin
         tick();
         checks++;
         if ({ready, stage, done} !== {m_ready, 2'(m_stage), m_done}) begin
            failures++;
            $display("FAIL w0 e%0d: got %b want %b", e,
                     {ready, stage, done}, {m_ready, 2'(m_stage), m_done});
         end
         if (e == 2 || e == 8 || e == 58) begin
            checks++;
            if (ready !== ((e == 2) ? 4'b0001 : 4'b1111)
                || stage !== ((e == 2) ? 2'd1 : 2'd3)) begin
               failures++;
               $display("FAIL w0_spot e%0d: got %b/%0d", e, ready, stage);
            end
         end
      end
   endtask

   task automatic test_hold();
      start(3);
      for (int e = 1; e <= 30; e++) begin
         hold = (e >= 7 && e <= 13);
         tick();
         checks++;
         if ({ready, stage, done} !== {m_ready, 2'(m_stage), m_done}) begin
            failures++;
            $display("FAIL hold e%0d: got %b want %b", e,
                     {ready, stage, done}, {m_ready, 2'(m_stage), m_done});
         end
         if (e == 16 || e == 17 || e == 22 || e == 27) begin
            checks++;
            if (ready !== ((e == 16) ? 4'b0001 : (e == 17) ? 4'b0011 :
                           (e == 22) ? 4'b0111 : 4'b1111)) begin
               failures++;
               $display("FAIL hold_spot e%0d: got %b", e, ready);
            end
         end
      end
      hold = 1'b0;
   endtask

   task automatic test_wait_change();
      start(3);
      for (int e = 1; e <= 20; e++) begin
         if (e == 3) wait_cycles = LG'(10);
         tick();
         checks++;
         if ({ready, stage, done} !== {m_ready, 2'(m_stage), m_done}) begin
            failures++;
            $display("FAIL wchg e%0d: got %b want %b", e,
                     {ready, stage, done}, {m_ready, 2'(m_stage), m_done});
         end
         if (e == 5 || e == 16 || e == 17) begin
            checks++;
            if (ready !== ((e == 5 || e == 16) ? 4'b0001 : 4'b0011)) begin
               failures++;
               $display("FAIL wchg_spot e%0d: got %b", e, ready);
            end
         end
      end
   endtask

   task automatic test_restart();
      start(3);
      for (int e = 1; e <= 25; e++) begin
         restart = (e == 20);
         tick();
         checks++;
         if ({ready, stage, done} !== {m_ready, 2'(m_stage), m_done}) begin
            failures++;
            $display("FAIL restart e%0d: got %b want %b", e,
                     {ready, stage, done}, {m_ready, 2'(m_stage), m_done});
         end
         if (e == 20 || e == 24 || e == 25) begin
            checks++;
            if (ready !== ((e == 25) ? 4'b0001 : 4'b0000) || done !== 1'b0) begin
               failures++;
               $display("FAIL restart_spot e%0d: got %b/%b", e, ready, done);
            end
         end
      end
      restart = 1'b0;
   endtask

   task automatic test_async_reset();
      start(3);
      for (int e = 1; e <= 12; e++) tick();
      #2;
      reset_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if ({ready, stage, done} !== 7'b0) begin
         failures++;
         $display("FAIL async_reset: got %b want %b",
                  {ready, stage, done}, 7'b0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         checks++;
         if ({ready, stage, done} !== {m_ready, 2'(m_stage), m_done}) begin
            failures++;
            $display("FAIL replay e%0d: got %b want %b", e,
                     {ready, stage, done}, {m_ready, 2'(m_stage), m_done});
         end
      end
   endtask

   task automatic test_wmax();
      start(255);
      for (int e = 1; e <= 4 * 257 + 3; e++) begin
         tick();
         checks++;
         if ({ready, stage, done} !== {m_ready, 2'(m_stage), m_done}) begin
            failures++;
            $display("FAIL wmax e%0d: got %b want %b", e,
                     {ready, stage, done}, {m_ready, 2'(m_stage), m_done});
         end
         if (e == 256 || e == 257 || e == 1028) begin
            checks++;
            if (ready !== ((e == 256) ? 4'b0000 : (e == 257) ? 4'b0001 :
                           4'b1111)) begin
               failures++;
               $display("FAIL wmax_spot e%0d: got %b", e, ready);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         start(int'($urandom_range(0, 6)));
         for (int e = 1; e <= 120; e++) begin
            hold = ($urandom_range(0, 3) == 0);
            restart = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0)
               wait_cycles = LG'($urandom_range(0, 6));
            tick();
            checks++;
            if ({ready, stage, done} !== {m_ready, 2'(m_stage), m_done}) begin
               failures++;
               $display("FAIL rand r%0d e%0d: got %b want %b", r, e,
                        {ready, stage, done},
                        {m_ready, 2'(m_stage), m_done});
            end
         end
      end
      hold = 1'b0;
      restart = 1'b0;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_w0();
      test_hold();
      test_wait_change();
      test_restart();
      test_async_reset();
      test_wmax();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
